// File: rtl/zx_bus_pkg.sv
// Shared types and constants for the ZX CPLD bus update sequencer.
package zx_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SRC_KEY,
    SRC_MOUSE,
    SRC_JOY
  } src_t;

  localparam logic [7:0] DI_IDLE       = 8'hFF;
  localparam int         KEY_ADDR_W    = 7;
  localparam int         KEY_XFER_BITS = 7;
  localparam logic [1:0] MOUSE_LAST_IDX = 2'd2;

  // Round-robin successor: key -> mouse -> joy -> key.
  function automatic src_t next_src(input src_t s);
    src_t r;
    case (s)
      SRC_KEY:   r = SRC_MOUSE;
      SRC_MOUSE: r = SRC_JOY;
      default:   r = SRC_KEY;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/zx_phase_timer.sv
// Loadable down-counter timing each bus phase; tc flags the last cycle.
module zx_phase_timer (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic       tc
);

  logic [3:0] count;

  // Load on phase entry, otherwise count down and rest at zero.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign tc = (count == 4'd0);

endmodule

// File: rtl/zx_bus_update_sequencer.sv
// Arbitrates mouse/joystick/keyboard updates and drives the CPLD write bus
// and keyboard serial interface, one transaction at a time.
module zx_bus_update_sequencer
  import zx_bus_pkg::*;
#(
  parameter int HALF_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       mouse_req,
  input  logic [7:0] mouse_x,
  input  logic [7:0] mouse_y,
  input  logic [7:0] mouse_btn,
  output logic       mouse_ack,
  input  logic       joy_req,
  input  logic [7:0] joy_data,
  output logic       joy_ack,
  input  logic       key_req,
  input  logic [6:0] key_addr,
  input  logic       key_state,
  output logic       key_ack,
  output logic [7:0] DI,
  output logic       MX,
  output logic       MY,
  output logic       MKEY,
  output logic       JOY,
  output logic       DAT,
  output logic       SK,
  output logic       STB,
  output logic       busy
);

  localparam logic [3:0] PHASE_LOAD = 4'(HALF_PERIOD - 1);
  localparam logic [2:0] LAST_BIT   = 3'(KEY_XFER_BITS - 1);

  state_t state_q, state_d;
  src_t   src_q;
  src_t   rr_q, rr_d;
  src_t   grant_src, cand;
  logic   grant_valid;

  logic [7:0]            byte0_q, byte1_q, byte2_q;
  logic [KEY_ADDR_W-1:0] key_addr_q;
  logic                  key_state_q;
  logic [2:0]            bit_q, bit_d;
  logic [1:0]            idx_q, idx_d;

  logic       timer_load;
  logic       tc;
  logic [7:0] cur_byte;
  logic       cur_bit;

  zx_phase_timer u_timer (
    .clk        (clk),
    .rst_in     (rst_in),
    .load       (timer_load),
    .load_value (PHASE_LOAD),
    .tc         (tc)
  );

  function automatic logic req_of(input src_t s, input logic k, input logic m, input logic j);
    logic r;
    case (s)
      SRC_KEY:   r = k;
      SRC_MOUSE: r = m;
      default:   r = j;
    endcase
    return r;
  endfunction

  // Round-robin pick: first requester starting from the current priority head.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = rr_q;
    cand        = rr_q;
    for (int i = 0; i < 3; i++) begin
      if (!grant_valid && req_of(cand, key_req, mouse_req, joy_req)) begin
        grant_valid = 1'b1;
        grant_src   = cand;
      end
      cand = next_src(cand);
    end
  end

  // State, counters and priority pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      bit_q   <= 3'd0;
      idx_q   <= 2'd0;
      rr_q    <= SRC_KEY;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
    end
  end

  // Snapshot the granted source's payload so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      src_q       <= SRC_KEY;
      byte0_q     <= 8'd0;
      byte1_q     <= 8'd0;
      byte2_q     <= 8'd0;
      key_addr_q  <= '0;
      key_state_q <= 1'b0;
    end else if (state_q == ST_IDLE && grant_valid) begin
      src_q       <= grant_src;
      byte0_q     <= (grant_src == SRC_JOY) ? joy_data : mouse_x;
      byte1_q     <= mouse_y;
      byte2_q     <= mouse_btn;
      key_addr_q  <= key_addr;
      key_state_q <= key_state;
    end
  end

  // Phase sequencing: each timed state runs until the phase timer expires.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    idx_d      = idx_q;
    rr_d       = rr_q;
    timer_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          rr_d       = next_src(grant_src);
          timer_load = 1'b1;
          bit_d      = 3'd0;
          idx_d      = 2'd0;
          state_d    = (grant_src == SRC_KEY) ? ST_SHIFT_LO : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tc) begin
          state_d    = ST_PULSE;
          timer_load = 1'b1;
        end
      end
      ST_PULSE: begin
        if (tc) begin
          state_d    = ST_HOLD;
          timer_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tc) begin
          if (src_q == SRC_MOUSE && idx_q != MOUSE_LAST_IDX) begin
            idx_d      = idx_q + 2'd1;
            state_d    = ST_SETUP;
            timer_load = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT_LO: begin
        if (tc) begin
          state_d    = ST_SHIFT_HI;
          timer_load = 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (tc) begin
          timer_load = 1'b1;
          bit_d      = bit_q + 3'd1;
          state_d    = (bit_q == LAST_BIT) ? ST_SETUP : ST_SHIFT_LO;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        bit_d   = 3'd0;
        idx_d   = 2'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus, strobe, serial and ack outputs decoded from the current state.
  always_comb begin
    DI        = DI_IDLE;
    MX        = 1'b0;
    MY        = 1'b0;
    MKEY      = 1'b0;
    JOY       = 1'b0;
    DAT       = 1'b0;
    SK        = 1'b0;
    STB       = 1'b0;
    mouse_ack = 1'b0;
    joy_ack   = 1'b0;
    key_ack   = 1'b0;
    busy      = (state_q != ST_IDLE);
    cur_bit   = key_addr_q[LAST_BIT - bit_q];
    case (idx_q)
      2'd0:    cur_byte = byte0_q;
      2'd1:    cur_byte = byte1_q;
      default: cur_byte = byte2_q;
    endcase
    case (state_q)
      ST_SETUP, ST_PULSE, ST_HOLD: begin
        if (src_q == SRC_KEY) begin
          DAT = key_state_q;
        end else begin
          DI = cur_byte;
        end
        if (state_q == ST_PULSE) begin
          if (src_q == SRC_KEY) begin
            STB = 1'b1;
          end else if (src_q == SRC_JOY) begin
            JOY = 1'b1;
          end else begin
            case (idx_q)
              2'd0:    MX   = 1'b1;
              2'd1:    MY   = 1'b1;
              default: MKEY = 1'b1;
            endcase
          end
        end
      end
      ST_SHIFT_LO: DAT = cur_bit;
      ST_SHIFT_HI: begin
        DAT = cur_bit;
        SK  = 1'b1;
      end
      ST_DONE: begin
        key_ack   = (src_q == SRC_KEY);
        mouse_ack = (src_q == SRC_MOUSE);
        joy_ack   = (src_q == SRC_JOY);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_zx_bus_update_sequencer.sv
// Directed bench for zx_bus_update_sequencer: per-cycle expectation tables
// plus hand-written round-robin and reset-abort sequences.
module tb_zx_bus_update_sequencer;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       mouse_req, joy_req, key_req, key_state;
  logic [7:0] mouse_x, mouse_y, mouse_btn, joy_data;
  logic [6:0] key_addr;
  logic       mouse_ack, joy_ack, key_ack;
  logic [7:0] DI;
  logic       MX, MY, MKEY, JOY, DAT, SK, STB, busy;

  logic       t1_mouse_req, t1_joy_req, t1_key_req, t1_key_state;
  logic [7:0] t1_mouse_x, t1_mouse_y, t1_mouse_btn, t1_joy_data;
  logic [6:0] t1_key_addr;
  logic       t1_mouse_ack, t1_joy_ack, t1_key_ack;
  logic [7:0] t1_DI;
  logic       t1_MX, t1_MY, t1_MKEY, t1_JOY, t1_DAT, t1_SK, t1_STB, t1_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          test_id;
    int          first;
    int          last;
    logic [18:0] exp;
  } seg_t;

  seg_t segs[$];

  zx_bus_update_sequencer #(.HALF_PERIOD(2)) dut (
    .clk(clk), .rst_in(rst_in),
    .mouse_req(mouse_req), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .mouse_btn(mouse_btn), .mouse_ack(mouse_ack),
    .joy_req(joy_req), .joy_data(joy_data), .joy_ack(joy_ack),
    .key_req(key_req), .key_addr(key_addr), .key_state(key_state), .key_ack(key_ack),
    .DI(DI), .MX(MX), .MY(MY), .MKEY(MKEY), .JOY(JOY),
    .DAT(DAT), .SK(SK), .STB(STB), .busy(busy)
  );

  zx_bus_update_sequencer #(.HALF_PERIOD(1)) dut1 (
    .clk(clk), .rst_in(rst_in),
    .mouse_req(t1_mouse_req), .mouse_x(t1_mouse_x), .mouse_y(t1_mouse_y),
    .mouse_btn(t1_mouse_btn), .mouse_ack(t1_mouse_ack),
    .joy_req(t1_joy_req), .joy_data(t1_joy_data), .joy_ack(t1_joy_ack),
    .key_req(t1_key_req), .key_addr(t1_key_addr), .key_state(t1_key_state),
    .key_ack(t1_key_ack),
    .DI(t1_DI), .MX(t1_MX), .MY(t1_MY), .MKEY(t1_MKEY), .JOY(t1_JOY),
    .DAT(t1_DAT), .SK(t1_SK), .STB(t1_STB), .busy(t1_busy)
  );

  always #5 clk = ~clk;

  // Flags order: MX MY MKEY JOY | STB SK DAT busy | key_ack mouse_ack joy_ack
  function automatic logic [18:0] mk(input logic [7:0] di, input logic [10:0] f);
    return {di, f};
  endfunction

  function automatic logic [18:0] obs0();
    return {DI, MX, MY, MKEY, JOY, STB, SK, DAT, busy, key_ack, mouse_ack, joy_ack};
  endfunction

  function automatic logic [18:0] obs1();
    return {t1_DI, t1_MX, t1_MY, t1_MKEY, t1_JOY, t1_STB, t1_SK, t1_DAT, t1_busy,
            t1_key_ack, t1_mouse_ack, t1_joy_ack};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic kreq, input logic [6:0] kaddr, input logic kst,
                               input logic mreq, input logic [7:0] mx, input logic [7:0] my,
                               input logic [7:0] mb, input logic jreq, input logic [7:0] jd);
    key_req   = kreq;
    key_addr  = kaddr;
    key_state = kst;
    mouse_req = mreq;
    mouse_x   = mx;
    mouse_y   = my;
    mouse_btn = mb;
    joy_req   = jreq;
    joy_data  = jd;
  endtask

  task automatic add_seg(input int id, input int f, input int l, input logic [18:0] e);
    seg_t s;
    s.test_id = id;
    s.first   = f;
    s.last    = l;
    s.exp     = e;
    segs.push_back(s);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    tick();
    tick();
    checkOutput("reset state dut", 32'(obs0()), 32'(mk(8'hFF, 11'b0000_0000_000)));
    checkOutput("reset state dut1", 32'(obs1()), 32'(mk(8'hFF, 11'b0000_0000_000)));
    rst_in = 1'b1;
  endtask

  // Walks one transaction cycle by cycle against its expectation segments.
  task automatic run_table(input int id, input int ncycles, input int sel);
    for (int c = 0; c < ncycles; c++) begin
      logic [18:0] e;
      logic        found;
      e     = '0;
      found = 1'b0;
      foreach (segs[k]) begin
        if (segs[k].test_id == id && c >= segs[k].first && c <= segs[k].last) begin
          e     = segs[k].exp;
          found = 1'b1;
        end
      end
      if (found) begin
        checkOutput($sformatf("test%0d cycle%0d", id, c),
                    32'((sel != 0) ? obs1() : obs0()), 32'(e));
      end
      if (c == 1) begin
        mouse_x     = 8'h00;
        mouse_y     = 8'hFF;
        mouse_btn   = 8'h55;
        joy_data    = 8'h00;
        key_addr    = 7'h7F;
        key_state   = 1'b0;
        t1_joy_data = 8'h00;
      end
      if (c == ncycles - 2) begin
        key_req    = 1'b0;
        mouse_req  = 1'b0;
        joy_req    = 1'b0;
        t1_joy_req = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    logic kb [7];
    int   n;
    int   got_src [4];
    int   got_cyc [4];
    int   exp_src [4];
    int   exp_cyc [4];
    int   acks;
    int   ack_cycle;

    rst_in = 1'b0;
    applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    t1_mouse_req = 1'b0; t1_joy_req = 1'b0; t1_key_req = 1'b0; t1_key_state = 1'b0;
    t1_mouse_x = 8'h00; t1_mouse_y = 8'h00; t1_mouse_btn = 8'h00; t1_joy_data = 8'h00;
    t1_key_addr = 7'h00;

    // Mouse x=12 y=34 btn=FA at T=2
    add_seg(1, 0, 0,   mk(8'hFF, 11'b0000_0000_000));
    add_seg(1, 1, 2,   mk(8'h12, 11'b0000_0001_000));
    add_seg(1, 3, 4,   mk(8'h12, 11'b1000_0001_000));
    add_seg(1, 5, 6,   mk(8'h12, 11'b0000_0001_000));
    add_seg(1, 7, 8,   mk(8'h34, 11'b0000_0001_000));
    add_seg(1, 9, 10,  mk(8'h34, 11'b0100_0001_000));
    add_seg(1, 11, 12, mk(8'h34, 11'b0000_0001_000));
    add_seg(1, 13, 14, mk(8'hFA, 11'b0000_0001_000));
    add_seg(1, 15, 16, mk(8'hFA, 11'b0010_0001_000));
    add_seg(1, 17, 18, mk(8'hFA, 11'b0000_0001_000));
    add_seg(1, 19, 19, mk(8'hFF, 11'b0000_0001_010));
    add_seg(1, 20, 20, mk(8'hFF, 11'b0000_0000_000));

    // Key addr=24h state=1 at T=2: bits 6..0 of 0100100
    kb = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    add_seg(2, 0, 0, mk(8'hFF, 11'b0000_0000_000));
    for (int i = 0; i < 7; i++) begin
      add_seg(2, 1 + 4 * i, 2 + 4 * i, mk(8'hFF, {6'b000000, kb[i], 1'b1, 3'b000}));
      add_seg(2, 3 + 4 * i, 4 + 4 * i, mk(8'hFF, {5'b00000, 1'b1, kb[i], 1'b1, 3'b000}));
    end
    add_seg(2, 29, 30, mk(8'hFF, 11'b0000_0011_000));
    add_seg(2, 31, 32, mk(8'hFF, 11'b0000_1011_000));
    add_seg(2, 33, 34, mk(8'hFF, 11'b0000_0011_000));
    add_seg(2, 35, 35, mk(8'hFF, 11'b0000_0001_100));
    add_seg(2, 36, 36, mk(8'hFF, 11'b0000_0000_000));

    // Joystick 3C at T=2
    add_seg(3, 0, 0, mk(8'hFF, 11'b0000_0000_000));
    add_seg(3, 1, 2, mk(8'h3C, 11'b0000_0001_000));
    add_seg(3, 3, 4, mk(8'h3C, 11'b0001_0001_000));
    add_seg(3, 5, 6, mk(8'h3C, 11'b0000_0001_000));
    add_seg(3, 7, 7, mk(8'hFF, 11'b0000_0001_001));
    add_seg(3, 8, 8, mk(8'hFF, 11'b0000_0000_000));

    // Joystick A5 at T=1
    add_seg(4, 0, 0, mk(8'hFF, 11'b0000_0000_000));
    add_seg(4, 1, 1, mk(8'hA5, 11'b0000_0001_000));
    add_seg(4, 2, 2, mk(8'hA5, 11'b0001_0001_000));
    add_seg(4, 3, 3, mk(8'hA5, 11'b0000_0001_000));
    add_seg(4, 4, 4, mk(8'hFF, 11'b0000_0001_001));
    add_seg(4, 5, 5, mk(8'hFF, 11'b0000_0000_000));

    do_reset();

    applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 8'h12, 8'h34, 8'hFA, 1'b0, 8'h00);
    run_table(1, 21, 0);

    applyStimulus(1'b1, 7'h24, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    run_table(2, 37, 0);

    applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h3C);
    run_table(3, 9, 0);

    t1_joy_req  = 1'b1;
    t1_joy_data = 8'hA5;
    run_table(4, 6, 1);

    // All three requesters held from reset: key, mouse, joy, key
    do_reset();
    exp_src = '{0, 1, 2, 0};
    exp_cyc = '{35, 55, 63, 99};
    got_src = '{-1, -1, -1, -1};
    got_cyc = '{-1, -1, -1, -1};
    n = 0;
    applyStimulus(1'b1, 7'h11, 1'b0, 1'b1, 8'h01, 8'h02, 8'h03, 1'b1, 8'h04);
    for (int c = 0; c < 200 && n < 4; c++) begin
      if (key_ack || mouse_ack || joy_ack) begin
        checkOutput("rr ack onehot", 32'($countones({key_ack, mouse_ack, joy_ack})), 32'd1);
        got_src[n] = key_ack ? 0 : (mouse_ack ? 1 : 2);
        got_cyc[n] = c;
        n++;
        if (n == 4) begin
          key_req   = 1'b0;
          mouse_req = 1'b0;
          joy_req   = 1'b0;
        end
      end
      tick();
    end
    if (n < 4) begin
      checks++;
      errors++;
      $display("[TB] FAIL rr timeout: got %0d acks required 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr source %0d", i), 32'(got_src[i]), 32'(exp_src[i]));
      checkOutput($sformatf("rr ack cycle %0d", i), 32'(got_cyc[i]), 32'(exp_cyc[i]));
    end
    tick();
    checkOutput("rr idle after", 32'(obs0()), 32'(mk(8'hFF, 11'b0000_0000_000)));

    // Reset in cycle 8 of a mouse transaction with the request held
    do_reset();
    acks      = 0;
    ack_cycle = -1;
    applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 8'h12, 8'h34, 8'hFA, 1'b0, 8'h00);
    for (int c = 0; c < 40; c++) begin
      if (mouse_ack) begin
        acks++;
        ack_cycle = c;
        mouse_req = 1'b0;
      end
      if (c == 8) begin
        checkOutput("abort pre-reset busy", 32'(busy), 32'd1);
        rst_in = 1'b0;
      end
      if (c == 9) begin
        checkOutput("abort idle values", 32'(obs0()), 32'(mk(8'hFF, 11'b0000_0000_000)));
        rst_in = 1'b1;
      end
      if (c == 12) begin
        checkOutput("restart MX strobe", 32'({MX, DI}), 32'({1'b1, 8'h12}));
      end
      tick();
    end
    checkOutput("abort ack count", 32'(acks), 32'd1);
    checkOutput("abort ack cycle", 32'(ack_cycle), 32'd28);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
